// File: rtl/reaction_trial_ctrl.sv
// Reaction-time trial sequencer: random foreperiod, stimulus, millisecond latency
// measurement, false-start and timeout detection. All outputs are registered.
module reaction_trial_ctrl #(
  parameter int N            = 8,
  parameter int TICKS_PER_MS = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int DELAY_SHIFT  = 3,
  parameter int MAX_MS       = 9999,
  parameter int RT_W         = 14
) (
  input  logic            clk,
  input  logic            iReset,
  input  logic            iStart,
  input  logic            iResponse,
  input  logic [N-1:0]    iRand,
  output logic            oStimulus,
  output logic            oBusy,
  output logic            oDone,
  output logic            oFalseStart,
  output logic            oTimeout,
  output logic [RT_W-1:0] oResult
);

  // Foreperiod register must hold the largest MIN + (iRand << SHIFT) without truncation.
  localparam longint unsigned DMAX = (((64'd1 << N) - 64'd1) << DELAY_SHIFT) + 64'(MIN_DELAY_MS);
  localparam int DW = $clog2(DMAX + 64'd1);
  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ARMED, S_DONE, S_FALSE} state_t;

  state_t            state, state_n;
  logic [TW-1:0]     tcnt, tcnt_n, tcnt_inc;
  logic [DW-1:0]     dly, dly_n, start_dly;
  logic [RT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [RT_W-1:0]   result_n;
  logic              stim_n, done_n, fs_n, to_n, busy_n;
  logic              ms_tick;

  assign ms_tick   = (tcnt == TW'(TICKS_PER_MS - 1));
  assign tcnt_inc  = ms_tick ? '0 : tcnt + TW'(1);
  assign cnt_inc   = cnt + RT_W'(1);
  assign start_dly = (DW'(iRand) << DELAY_SHIFT) + DW'(MIN_DELAY_MS);

  always_ff @(posedge clk) begin
    if (!iReset) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      dly         <= '0;
      cnt         <= '0;
      oResult     <= '0;
      oStimulus   <= 1'b0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oFalseStart <= 1'b0;
      oTimeout    <= 1'b0;
    end else begin
      state       <= state_n;
      tcnt        <= tcnt_n;
      dly         <= dly_n;
      cnt         <= cnt_n;
      oResult     <= result_n;
      oStimulus   <= stim_n;
      oBusy       <= busy_n;
      oDone       <= done_n;
      oFalseStart <= fs_n;
      oTimeout    <= to_n;
    end
  end

  always_comb begin
    state_n  = state;
    tcnt_n   = tcnt;
    dly_n    = dly;
    cnt_n    = cnt;
    result_n = oResult;
    stim_n   = oStimulus;
    done_n   = oDone;
    fs_n     = oFalseStart;
    to_n     = oTimeout;
    case (state)
      S_IDLE, S_DONE, S_FALSE: begin
        if (iStart) begin
          state_n  = S_WAIT;
          dly_n    = start_dly;
          tcnt_n   = '0;
          cnt_n    = '0;
          result_n = '0;
          done_n   = 1'b0;
          fs_n     = 1'b0;
          to_n     = 1'b0;
        end
      end
      S_WAIT: begin
        tcnt_n = tcnt_inc;
        // An early response beats the final ms tick of the foreperiod.
        if (iResponse) begin
          state_n  = S_FALSE;
          fs_n     = 1'b1;
          result_n = '0;
          tcnt_n   = '0;
        end else if (ms_tick) begin
          if (dly == DW'(1)) begin
            state_n = S_ARMED;
            tcnt_n  = '0;
            cnt_n   = '0;
            stim_n  = 1'b1;
          end else begin
            dly_n = dly - DW'(1);
          end
        end
      end
      S_ARMED: begin
        tcnt_n = tcnt_inc;
        if (ms_tick) cnt_n = cnt_inc;
        if (iResponse) begin
          state_n  = S_DONE;
          result_n = ms_tick ? cnt_inc : cnt;
          stim_n   = 1'b0;
          done_n   = 1'b1;
        end else if (ms_tick && (cnt_inc == RT_W'(MAX_MS))) begin
          state_n  = S_DONE;
          result_n = RT_W'(MAX_MS);
          stim_n   = 1'b0;
          done_n   = 1'b1;
          to_n     = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n == S_WAIT) || (state_n == S_ARMED);
  end

endmodule

// File: tb/tb_reaction_trial_ctrl.sv
// Directed bench for reaction_trial_ctrl with a 4-cycle millisecond and a short timeout.
module tb_reaction_trial_ctrl;
  localparam int N = 8, TPM = 4, MIND = 2, SH = 1, MAXMS = 20, RT_W = 14;

  logic            clk = 1'b0;
  logic            iReset, iStart, iResponse;
  logic [N-1:0]    iRand;
  logic            oStimulus, oBusy, oDone, oFalseStart, oTimeout;
  logic [RT_W-1:0] oResult;

  int total = 0;
  int passed = 0;

  reaction_trial_ctrl #(.N(N), .TICKS_PER_MS(TPM), .MIN_DELAY_MS(MIND), .DELAY_SHIFT(SH),
                        .MAX_MS(MAXMS), .RT_W(RT_W)) dut (
    .clk(clk), .iReset(iReset), .iStart(iStart), .iResponse(iResponse), .iRand(iRand),
    .oStimulus(oStimulus), .oBusy(oBusy), .oDone(oDone), .oFalseStart(oFalseStart),
    .oTimeout(oTimeout), .oResult(oResult));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic start_trial(input int r);
    iRand  = N'(r);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
  endtask

  // Counts edges after the start edge until the stimulus shows, bounded.
  task automatic wait_stim(input string tag, input int exp);
    int n = 0;
    while (!oStimulus && n < exp + 50) begin
      step();
      n++;
    end
    chk(tag, n, exp);
  endtask

  // Response sampled m edges after the stimulus edge (current time is just after it).
  task automatic respond_after(input int m);
    for (int i = 0; i < m - 1; i++) step();
    iResponse = 1'b1;
    step();
    iResponse = 1'b0;
  endtask

  initial begin
    int n, hits;
    iReset = 1'b0; iStart = 1'b0; iResponse = 1'b0; iRand = '0;

    // Reset with toggling inputs
    for (int i = 0; i < 3; i++) begin
      iStart = i[0]; iResponse = ~i[0];
      step();
    end
    chk("reset_outs", int'({oStimulus, oBusy, oDone, oFalseStart, oTimeout, oResult}), 0);
    iReset = 1'b1; iStart = 1'b0; iResponse = 1'b0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin step(); if (oStimulus || oBusy) hits++; end
    chk("reset_no_stim", hits, 0);

    // Normal trial; iRand change and iStart pulse during WAIT must not disturb it
    start_trial(3);
    chk("normal_busy", int'(oBusy), 1);
    iRand = 8'd255;
    n = 0;
    while (!oStimulus && n < 100) begin
      iStart = (n == 10);
      step();
      n++;
    end
    iStart = 1'b0;
    chk("normal_foreperiod", n, 32);
    chk("armed_busy", int'(oBusy), 1);
    respond_after(21);
    chk("normal_result", int'(oResult), 5);
    chk("normal_flags", int'({oDone, oStimulus, oTimeout, oBusy, oFalseStart}), 5'b10000);

    // Back-to-back start from DONE, then a false start
    start_trial(3);
    chk("b2b_clear", int'({oDone, oResult}), 0);
    chk("b2b_busy", int'(oBusy), 1);
    for (int i = 0; i < 9; i++) step();
    iResponse = 1'b1; step(); iResponse = 1'b0;
    chk("false_flags", int'({oFalseStart, oDone, oStimulus, oBusy}), 4'b1000);
    chk("false_result", int'(oResult), 0);
    hits = 0;
    for (int i = 0; i < 50; i++) begin step(); if (oStimulus || !oFalseStart) hits++; end
    chk("false_hold", hits, 0);

    // Response on the very edge the stimulus would rise
    start_trial(3);
    chk("false_cleared", int'(oFalseStart), 0);
    respond_after(32);
    chk("false_edge", int'({oFalseStart, oStimulus, oDone}), 3'b100);

    // Timeout
    start_trial(0);
    wait_stim("to_foreperiod", 8);
    for (int i = 0; i < 79; i++) step();
    chk("to_before", int'({oDone, oStimulus}), 2'b01);
    step();
    chk("to_flags", int'({oDone, oTimeout, oStimulus, oBusy}), 4'b1100);
    chk("to_result", int'(oResult), MAXMS);

    // Response on the timeout edge counts as a response
    start_trial(0);
    wait_stim("rto_foreperiod", 8);
    respond_after(80);
    chk("rto_result", int'(oResult), MAXMS);
    chk("rto_flags", int'({oDone, oTimeout}), 2'b10);

    // Millisecond boundary: m=3 -> 0, m=4 -> 1
    start_trial(0);
    wait_stim("b3_foreperiod", 8);
    respond_after(3);
    chk("m3_result", int'(oResult), 0);
    start_trial(0);
    wait_stim("b4_foreperiod", 8);
    respond_after(4);
    chk("m4_result", int'(oResult), 1);

    // Widest foreperiod needs the full-width add
    start_trial(255);
    wait_stim("max_foreperiod", 2048);
    respond_after(8);
    chk("max_result", int'(oResult), 2);

    // Reset mid-ARMED, then a normal trial
    start_trial(0);
    wait_stim("rst_foreperiod", 8);
    for (int i = 0; i < 5; i++) step();
    iReset = 1'b0; step();
    chk("rst_armed", int'({oStimulus, oBusy, oDone, oFalseStart, oTimeout, oResult}), 0);
    iReset = 1'b1;
    step();
    chk("rst_idle", int'({oStimulus, oBusy}), 0);
    start_trial(3);
    wait_stim("post_rst_foreperiod", 32);
    respond_after(21);
    chk("post_rst_result", int'(oResult), 5);
    chk("post_rst_done", int'(oDone), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
